buzzer_arbiter: RTL



---
 rtl/buzzer_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: grants the single board buzzer to the g-sensor or light-sensor
// alarm by urgency, with a minimum hold time, round-robin on ties and internal beep timing.
//
// state   | meaning
// IDLE    | no owner, buzzer silent
// SERVE_G | g-sensor owns the buzzer
// SERVE_L | light sensor owns the buzzer
module buzzer_arbiter #(
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 500,
    parameter int HALF_L1    = 500,
    parameter int HALF_L2    = 250,
    parameter int HALF_L3    = 100,
    parameter int HALF_L4    = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [2:0] req_g,
    input  logic [2:0] req_l,
    output logic       alarm,
    output logic [1:0] grant,
    output logic [2:0] cur_level
);

    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam int HALF_M12  = (HALF_L1 > HALF_L2) ? HALF_L1 : HALF_L2;
    localparam int HALF_M34  = (HALF_L3 > HALF_L4) ? HALF_L3 : HALF_L4;
    localparam int HALF_MAX  = (HALF_M12 > HALF_M34) ? HALF_M12 : HALF_M34;
    localparam int HALF_W    = $clog2(HALF_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_G = 2'd1,
        SERVE_L = 2'd2
    } state_t;

    state_t              state;
    logic                rr;        // 0 = g-sensor wins the next tie, 1 = light
    logic [TICK_W-1:0]   pre_cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                tick;
    logic [2:0]          lvl_g;
    logic [2:0]          lvl_l;
    logic [2:0]          own_lvl;
    logic [HALF_W-1:0]   half_inc;
    logic                go_g;
    logic                go_l;
    logic                go_idle;

    function automatic logic [2:0] sat_level(input logic [2:0] req);
        return (req > 3'd4) ? 3'd4 : req;
    endfunction

    function automatic logic [HALF_W-1:0] half_of(input logic [2:0] lvl);
        case (lvl)
            3'd1:    return HALF_W'(HALF_L1);
            3'd2:    return HALF_W'(HALF_L2);
            3'd3:    return HALF_W'(HALF_L3);
            default: return HALF_W'(HALF_L4);
        endcase
    endfunction

    assign lvl_g    = sat_level(req_g);
    assign lvl_l    = sat_level(req_l);
    assign own_lvl  = (state == SERVE_L) ? lvl_l : lvl_g;
    assign tick     = (pre_cnt == TICK_W'(TICK_DIV - 1));
    assign half_inc = half_cnt + HALF_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + TICK_W'(1);
        end
    end

    // Transition decode; at most one of go_g / go_l / go_idle is set.
    always_comb begin
        go_g    = 1'b0;
        go_l    = 1'b0;
        go_idle = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && (lvl_g != 3'd0 || lvl_l != 3'd0)) begin
                    if (lvl_g > lvl_l || (lvl_g == lvl_l && !rr)) go_g = 1'b1;
                    else                                          go_l = 1'b1;
                end
            end
            SERVE_G: begin
                if (!enable)                                       go_idle = 1'b1;
                else if (lvl_g == 3'd0) begin
                    if (lvl_l != 3'd0) go_l    = 1'b1;
                    else               go_idle = 1'b1;
                end else if (hold_cnt == '0 && lvl_l >= lvl_g)      go_l = 1'b1;
            end
            SERVE_L: begin
                if (!enable)                                       go_idle = 1'b1;
                else if (lvl_l == 3'd0) begin
                    if (lvl_g != 3'd0) go_g    = 1'b1;
                    else               go_idle = 1'b1;
                end else if (hold_cnt == '0 && lvl_g >= lvl_l)      go_g = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            half_cnt  <= '0;
            hold_cnt  <= '0;
            alarm     <= 1'b0;
            grant     <= 2'b00;
            cur_level <= 3'd0;
        end else if (go_g || go_l) begin
            state     <= go_g ? SERVE_G : SERVE_L;
            rr        <= go_g;
            half_cnt  <= '0;
            hold_cnt  <= HOLD_W'(HOLD_TICKS);
            alarm     <= 1'b1;
            grant     <= go_g ? 2'b01 : 2'b10;
            cur_level <= go_g ? lvl_g : lvl_l;
        end else if (go_idle) begin
            state     <= IDLE;
            half_cnt  <= '0;
            hold_cnt  <= '0;
            alarm     <= 1'b0;
            grant     <= 2'b00;
            cur_level <= 3'd0;
        end else if (state != IDLE) begin
            cur_level <= own_lvl;
            if (tick) begin
                // Compare against the live level so a shortened period takes effect at once.
                if (half_inc >= half_of(own_lvl)) begin
                    alarm    <= ~alarm;
                    half_cnt <= '0;
                end else begin
                    half_cnt <= half_inc;
                end
                if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule
